fp_align_shift_pipe: RTL and testbench
======================================

Name: fp_align_shift_pipe

Overview:
Parametrised alignment stage for the floating-point adder datapath. It takes the smaller-exponent operand and an exponent difference, restores the hidden bit (denormal-aware), and right-shifts the significand. It produces guard, round and sticky bits, so downstream rounding is exact. It is a 2-stage valid/ready pipeline that replaces the single-register, fixed-width shifter and feeds the significand adder.

Parameters:
EXP_W, 8, exponent field width.
MAN_W, 23, stored mantissa width, without the hidden bit.
(Derived, not overridable) OP_W = 1+EXP_W+MAN_W; SIG_W = MAN_W+4.

Ports:
clk  input  1  rising-edge clock
res  input  1  reset, asynchronous, active-low
in_valid  input  1  input beat valid
in_ready  output  1  block can accept an input beat
in_op  input  OP_W  IEEE-style operand {sign, exp, man}
in_shift  input  EXP_W  unsigned right-shift amount (exponent difference)
in_exp  input  EXP_W  result exponent (larger operand); passed through unchanged
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the output beat
out_sign  output  1  sign of in_op
out_exp  output  EXP_W  registered in_exp
out_sig  output  SIG_W  {kept[MAN_W:0], G, R, S}

Behaviour:
- Reset (res low, asynchronous): both stage valids cleared; out_valid, out_sign, out_exp and out_sig all 0. The reset clears any beat in flight; no partial output survives. in_ready is 1 one cycle after release.
- Handshake: a beat transfers when valid && ready. A stage advances when it is empty or when its downstream stage accepts in the same cycle.
  - in_ready = !s1_valid || s1_adv.
  - s2 accepts when !out_valid || out_ready.
  - Full throughput is 1 beat/cycle with no bubbles.
- Latency: 2 cycles from input accept to out_valid, with out_ready held high.
- Stall: while out_valid && !out_ready, the out_* signals hold stable and s1 holds its data.
- Stage 1 (register):
  - sign registered as-is.
  - hid = (exp field != 0); sig = {hid, man}, MAN_W+1 bits.
  - shamt clamped: sh = min(in_shift, MAN_W+3).
  - in_exp registered.
- Stage 2 (shift):
  - Exact value is sig * 2^-sh.
  - kept = sig >> sh.
  - G = first bit below kept LSB; R = next bit; S = OR of all remaining lower bits.
  - sh = 0: G = R = S = 0.
  - sh = MAN_W+1: kept = 0, G = sig[MAN_W], R = sig[MAN_W-1], S = |sig[MAN_W-2:0].
  - sh >= MAN_W+3 (clamped): kept = 0, G = R = 0, S = |sig.
- Zero operand (exp = man = 0): out_sig = 0 for any shift.
- No state beyond the two stage registers. Simultaneous in-accept and out-accept on a full pipe is legal and loses no beat.
- Inf/NaN operands: no special handling; the encoding is treated as a normal number with hidden bit 1. Detection is upstream's responsibility.

Decomposition:
- Shared package fp_pkg holds:
  - default EXP_W/MAN_W constants;
  - derived widths OP_W and SIG_W;
  - the bit-position constants for G/R/S within out_sig.
- One sub-module, fp_sticky_shifter: combinational, parameterised by MAN_W. Inputs sig and sh; outputs kept, G, R, S. Stage 2 instantiates it between its input and output registers.

Test Plan:
- Reset/idle: res low mid-stream -> out_valid=0, out_sig=0 immediately; after release in_ready=1, first output appears exactly 2 cycles after accept.
- Basic shift: in_op=0x3FC00000, in_shift=1, in_exp=0x80 -> out_sig={0x600000,0,0,0}=0x3000000, out_exp=0x80, out_sign=0.
- Guard/round boundary: in_op=0x3FC00000, in_shift=24 -> kept=0, G=1, R=1, S=0 (out_sig=0x0000006). Same operand with in_shift=25 -> G=0, R=1, S=1 (out_sig=0x0000003).
- Clamp/sticky: in_op=0xBF800001, in_shift=200 -> out_sig=0x0000001, out_sign=1. in_op=0x00000000, in_shift=200 -> out_sig=0.
- Denormal: in_op=0x00000001, in_shift=0 -> out_sig=0x0000008 (hidden bit 0).
- Backpressure/throughput: stream 10 back-to-back beats while out_ready toggles in a random pattern -> every beat delivered once, in order, with no out_* change while stalled. With out_ready=1 throughout: 1 beat/cycle.

Source files
------------

// File: rtl/fp_align_shift_pipe_pkg.sv
// Shared constants for the floating-point alignment datapath.
//   - default field widths (binary32)
//   - derived width helpers: op_w (operand width) and sig_w (out_sig width)
//   - shift-amount helpers: sh_max (clamp value) and sh_w (register width)
//   - bit positions of guard/round/sticky inside out_sig
package fp_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned MAN_W_DEF = 23;

    localparam int unsigned G_POS = 2;
    localparam int unsigned R_POS = 1;
    localparam int unsigned S_POS = 0;

    // {sign, exp, man}
    function automatic int unsigned op_w(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    // {kept[MAN_W:0], G, R, S}
    function automatic int unsigned sig_w(input int unsigned man_w);
        return man_w + 4;
    endfunction

    // Any shift at or beyond this moves every significand bit below R
    function automatic int unsigned sh_max(input int unsigned man_w);
        return man_w + 3;
    endfunction

    function automatic int unsigned sh_w(input int unsigned man_w);
        return $clog2(man_w + 4);
    endfunction

endpackage

// File: rtl/fp_align_shift_pipe_if.sv
// Handshake bundle for fp_align_shift_pipe.
//   in_valid/in_ready   : input beat handshake
//   in_op/in_shift/in_exp : operand, right-shift amount, passthrough exponent
//   out_valid/out_ready : output beat handshake
//   out_sign/out_exp/out_sig : aligned result
// master = producer/consumer around the block, slave = the block itself.
interface fp_align_shift_pipe_if import fp_pkg::*; #(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
);
    localparam int unsigned OP_W  = op_w(EXP_W, MAN_W);
    localparam int unsigned SIG_W = sig_w(MAN_W);

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [EXP_W-1:0] in_shift;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [SIG_W-1:0] out_sig;

    modport master (
        output in_valid, in_op, in_shift, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig
    );

    modport slave (
        input  in_valid, in_op, in_shift, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig
    );

endinterface

// File: rtl/fp_align_shift_pipe_sticky_shifter.sv
// Combinational right shifter with guard/round/sticky extraction.
//   sig_i  : {hidden, man}, MAN_W+1 bits
//   sh_i   : right-shift amount, expected already clamped to MAN_W+3
//   kept_o : sig_i >> sh_i
//   g_o/r_o: first and second bit below the kept LSB
//   s_o    : OR of every bit below R
module fp_sticky_shifter import fp_pkg::*; #(
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic [MAN_W:0]            sig_i,
    input  logic [sh_w(MAN_W)-1:0]    sh_i,
    output logic [MAN_W:0]            kept_o,
    output logic                      g_o,
    output logic                      r_o,
    output logic                      s_o
);
    // MAN_W+3 zero bits below sig leave room for G, R and a full-width
    // sticky window, so a shift of MAN_W+3 still keeps sig[0] in view.
    localparam int unsigned W = 2 * MAN_W + 4;

    logic [W-1:0] wide;

    always_comb begin
        wide   = {sig_i, {(MAN_W + 3){1'b0}}} >> sh_i;
        kept_o = wide[W-1 -: MAN_W + 1];
        g_o    = wide[MAN_W + 2];
        r_o    = wide[MAN_W + 1];
        s_o    = |wide[MAN_W:0];
    end

endmodule

// File: rtl/fp_align_shift_pipe.sv
// Two-stage valid/ready alignment stage for the FP adder.
// Stage 1 registers sign, significand with restored hidden bit, clamped
// shift and passthrough exponent. Stage 2 shifts and registers the result
// with guard/round/sticky appended.
//   clk : rising-edge clock
//   res : asynchronous active-low reset
//   bus : fp_align_shift_pipe_if slave (in_* / out_* handshake and data)
module fp_align_shift_pipe import fp_pkg::*; #(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic                 clk,
    input  logic                 res,
    fp_align_shift_pipe_if.slave bus
);
    localparam int unsigned OP_W   = op_w(EXP_W, MAN_W);
    localparam int unsigned SIG_W  = sig_w(MAN_W);
    localparam int unsigned SH_W   = sh_w(MAN_W);
    localparam int unsigned SH_MAX = sh_max(MAN_W);

    // Stage 1
    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q,  s1_sign_d;
    logic [MAN_W:0]   s1_sig_q,   s1_sig_d;
    logic [SH_W-1:0]  s1_sh_q,    s1_sh_d;
    logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;

    // Stage 2 (output registers)
    logic             out_valid_q, out_valid_d;
    logic             out_sign_q,  out_sign_d;
    logic [EXP_W-1:0] out_exp_q,   out_exp_d;
    logic [SIG_W-1:0] out_sig_q,   out_sig_d;

    logic             s2_accept;
    logic             s1_adv;
    logic             in_ready;
    logic [31:0]      sh_full;

    logic [MAN_W:0]   kept;
    logic             g_bit, r_bit, s_bit;

    fp_sticky_shifter #(.MAN_W(MAN_W)) u_shifter (
        .sig_i  (s1_sig_q),
        .sh_i   (s1_sh_q),
        .kept_o (kept),
        .g_o    (g_bit),
        .r_o    (r_bit),
        .s_o    (s_bit)
    );

    always_comb begin
        s2_accept = !out_valid_q || bus.out_ready;
        s1_adv    = s1_valid_q && s2_accept;
        in_ready  = !s1_valid_q || s1_adv;
        sh_full   = 32'(bus.in_shift);

        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_sig_d   = s1_sig_q;
        s1_sh_d    = s1_sh_q;
        s1_exp_d   = s1_exp_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (in_ready && bus.in_valid) begin
            s1_sign_d = bus.in_op[OP_W-1];
            // Hidden bit is 0 only for a zero exponent field (denormal/zero)
            s1_sig_d  = {|bus.in_op[OP_W-2 -: EXP_W], bus.in_op[MAN_W-1:0]};
            s1_sh_d   = (sh_full > SH_MAX) ? SH_W'(SH_MAX) : SH_W'(sh_full);
            s1_exp_d  = bus.in_exp;
        end

        out_valid_d = s2_accept ? s1_valid_q : out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_sig_d   = out_sig_q;
        if (s1_adv) begin
            out_sign_d       = s1_sign_q;
            out_exp_d        = s1_exp_q;
            out_sig_d        = {kept, 3'b000};
            out_sig_d[G_POS] = g_bit;
            out_sig_d[R_POS] = r_bit;
            out_sig_d[S_POS] = s_bit;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_sig_q    <= '0;
            s1_sh_q     <= '0;
            s1_exp_q    <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_sig_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_sig_q    <= s1_sig_d;
            s1_sh_q     <= s1_sh_d;
            s1_exp_q    <= s1_exp_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_sig_q   <= out_sig_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_sig   = out_sig_q;

endmodule

// File: tb/tb_fp_align_shift_pipe.sv
// Self-checking bench for fp_align_shift_pipe (binary32 configuration).
module tb_fp_align_shift_pipe;
    import fp_pkg::*;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    fp_align_shift_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_align_shift_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [26:0] sig;
    } beat_t;

    typedef struct {
        logic [31:0] op;
        logic [7:0]  shift;
        logic [7:0]  exp;
        logic        sign;
        logic [26:0] sig;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    // Reference: exact value sig * 2^-shift as integer part plus fraction.
    // Shifts past 40 give the same G/R/S as 40 for a 24-bit significand.
    function automatic logic [26:0] model_sig(input logic [31:0] op, input logic [7:0] shift);
        longint unsigned sig, pw, kept, rem, scaled, gr;
        int unsigned n;
        bit sticky;
        sig    = (op[30:23] != 8'd0) ? ((64'd1 << 23) | 64'(op[22:0])) : 64'(op[22:0]);
        n      = (shift > 8'd40) ? 40 : int'(shift);
        pw     = 64'd1 << n;
        kept   = sig / pw;
        rem    = sig % pw;
        scaled = rem * 4;          // fraction * 4, still scaled by pw
        gr     = scaled / pw;      // {G, R}
        sticky = (scaled % pw) != 0;
        return 27'((kept << 3) | (gr << 1) | 64'(sticky));
    endfunction

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_shift  = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b1;
    endtask

    // Single beat into an empty pipe; lat = clock edges from drive to out_valid
    task automatic send_one(input logic [31:0] op, input logic [7:0] sh, input logic [7:0] e,
                            output beat_t got, output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_shift  = sh;
        bus.in_exp    = e;
        bus.out_ready = 1'b1;
        #1;
        check("send_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = {bus.out_sign, bus.out_exp, bus.out_sig};
    endtask

    task automatic run_stream(input int nbeats, input bit rand_in, input bit rand_out,
                              input bit full_rate, input string tag);
        beat_t q[$];
        beat_t prev;
        beat_t exp_b;
        logic [31:0] op;
        logic [7:0]  sh, e;
        int sent = 0, recv = 0, cyc = 0;
        bit stalled = 1'b0;
        prev = '0;
        while (recv < nbeats && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (stalled)
                check({tag, "_stall_hold"},
                      64'({bus.out_valid, bus.out_sign, bus.out_exp, bus.out_sig}),
                      64'({1'b1, prev}));
            if (sent < nbeats && (!rand_in || $urandom_range(0, 3) != 0)) begin
                op = $urandom();
                case ($urandom_range(0, 3))
                    0:       op[30:23] = 8'd0;
                    1:       op[30:0]  = 31'd0;
                    default: ;
                endcase
                sh = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom());
                e  = 8'($urandom());
                bus.in_valid = 1'b1;
                bus.in_op    = op;
                bus.in_shift = sh;
                bus.in_exp   = e;
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (full_rate && sent < nbeats)
                check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
            if (bus.in_valid && bus.in_ready) begin
                q.push_back({bus.in_op[31], bus.in_exp, model_sig(bus.in_op, bus.in_shift)});
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check({tag, "_unexpected_beat"}, 64'd1, 64'd0);
                end else begin
                    exp_b = q.pop_front();
                    check({tag, "_beat"}, 64'({bus.out_sign, bus.out_exp, bus.out_sig}), 64'(exp_b));
                end
                recv++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            prev    = {bus.out_sign, bus.out_exp, bus.out_sig};
        end
        check({tag, "_delivered"}, 64'(recv), 64'(nbeats));
        check({tag, "_leftover"}, 64'(q.size()), 64'd0);
        if (full_rate)
            check({tag, "_cycles"}, 64'(cyc), 64'(nbeats + 2));
        @(negedge clk);
        idle_inputs();
    endtask

    vec_t  vecs[9];
    beat_t got;
    int    lat;

    initial begin
        vecs[0] = '{32'h3FC00000, 8'd1,   8'h80, 1'b0, 27'h3000000};
        vecs[1] = '{32'h3FC00000, 8'd24,  8'h80, 1'b0, 27'h0000006};
        vecs[2] = '{32'h3FC00000, 8'd25,  8'h80, 1'b0, 27'h0000003};
        vecs[3] = '{32'hBF800001, 8'd200, 8'h81, 1'b1, 27'h0000001};
        vecs[4] = '{32'h00000000, 8'd200, 8'h10, 1'b0, 27'h0000000};
        vecs[5] = '{32'h00000001, 8'd0,   8'h00, 1'b0, 27'h0000008};
        vecs[6] = '{32'h3FC00000, 8'd0,   8'h55, 1'b0, 27'h6000000};
        vecs[7] = '{32'h3F800001, 8'd26,  8'h7F, 1'b0, 27'h0000001};
        vecs[8] = '{32'h3F800001, 8'd23,  8'h7F, 1'b0, 27'h0000009};

        idle_inputs();
        #2 res = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_sig", 64'(bus.out_sig), 64'd0);
        res = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            send_one(vecs[i].op, vecs[i].shift, vecs[i].exp, got, lat);
            check($sformatf("vec%0d_sig", i), 64'(got.sig), 64'(vecs[i].sig));
            check($sformatf("vec%0d_sign", i), 64'(got.sign), 64'(vecs[i].sign));
            check($sformatf("vec%0d_exp", i), 64'(got.exp), 64'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
        end

        // Mid-stream asynchronous reset with a full, stalled pipe
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = 32'h3FC00000;
        bus.in_shift  = 8'd0;
        bus.in_exp    = 8'h42;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        check("stall_full_out_valid", 64'(bus.out_valid), 64'd1);
        check("stall_full_in_ready", 64'(bus.in_ready), 64'd0);
        #2 res = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_reset_out_sig", 64'(bus.out_sig), 64'd0);
        check("async_reset_out_exp", 64'(bus.out_exp), 64'd0);
        check("async_reset_out_sign", 64'(bus.out_sign), 64'd0);
        @(negedge clk);
        res = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_reset_no_stale", 64'(bus.out_valid), 64'd0);
        end
        send_one(32'hBF800001, 8'd200, 8'h33, got, lat);
        check("after_reset_latency", 64'(lat), 64'd2);
        check("after_reset_beat", 64'(got), 64'({1'b1, 8'h33, 27'h0000001}));

        // Streaming against the scoreboard
        run_stream(10, 1'b0, 1'b1, 1'b0, "bp10");
        run_stream(10, 1'b0, 1'b0, 1'b1, "rate10");
        run_stream(200, 1'b1, 1'b1, 1'b0, "rand200");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
